// File: rtl/ib_pingpong.sv
// ib_pingpong: double-banked (ping-pong) input buffer for the CNN datapath.
// The writer fills one bank from the upstream stream while the reader streams the
// other bank to the PE array. Each read of a bank can be replayed several times
// before the bank is released back to the writer.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   clr            synchronous clear, same effect as reset, overrides everything
//   in_valid/in_ready/in_data      upstream write handshake
//   rd_start, rd_passes            start streaming the read bank, pass count (0 -> 1)
//   out_valid/out_ready/out_data   registered downstream handshake
//   out_last       final word of the final pass
//   bank_full      per-bank full flags
//   rd_busy        read FSM streaming
//   wr_addr        next write index in the write bank
//   cbuffer        whole read bank in parallel, word 0 in the LSBs

module ib_pingpong #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     rd_start,
    input  logic [7:0]               rd_passes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic [1:0]               bank_full,
    output logic                     rd_busy,
    output logic [AW-1:0]            wr_addr,
    output logic [DEPTH*WIDTH-1:0]   cbuffer
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic             wr_bank_q;
    logic             rd_bank_q;
    logic [AW-1:0]    rd_addr_q;
    logic [7:0]       pass_q;
    logic [7:0]       passes_q;
    state_e           state_q;

    logic             do_write;
    logic             slot_free;
    logic             issue_last;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    assign in_ready   = !bank_full[wr_bank_q];
    assign do_write   = in_valid && in_ready;
    assign slot_free  = !out_valid || out_ready;
    assign wr_idx     = wr_addr[IW-1:0];
    assign rd_idx     = rd_addr_q[IW-1:0];
    assign issue_last = (rd_addr_q == LastAddr) && (pass_q == passes_q - 8'd1);
    assign rd_busy    = (state_q == StStream);

    always_comb begin
        cbuffer = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cbuffer[i*WIDTH +: WIDTH] = mem_q[rd_bank_q][IW'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[1'(b)][IW'(i)] <= '0;
                end
            end
            bank_full <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr   <= '0;
            rd_addr_q <= '0;
            pass_q    <= '0;
            passes_q  <= '0;
            state_q   <= StIdle;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[1'(b)][IW'(i)] <= '0;
                end
            end
            bank_full <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr   <= '0;
            rd_addr_q <= '0;
            pass_q    <= '0;
            passes_q  <= '0;
            state_q   <= StIdle;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            // Writer only touches a non-full bank and the reader only releases a full
            // one, so the two bank_full updates below never hit the same bit.
            if (do_write) begin
                mem_q[wr_bank_q][wr_idx] <= in_data;
                if (wr_addr == LastAddr) begin
                    bank_full[wr_bank_q] <= 1'b1;
                    wr_bank_q            <= ~wr_bank_q;
                    wr_addr              <= '0;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    // Drain the final word of the previous stream.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                    end
                    // Word 0 is issued on the accepting edge so out_valid rises next cycle.
                    if (rd_start && bank_full[rd_bank_q] && slot_free) begin
                        passes_q  <= (rd_passes == 8'd0) ? 8'd1 : rd_passes;
                        pass_q    <= '0;
                        rd_addr_q <= AW'(1);
                        out_data  <= mem_q[rd_bank_q][IW'(0)];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state_q   <= StStream;
                    end
                end
                StStream: begin
                    if (slot_free) begin
                        out_data  <= mem_q[rd_bank_q][rd_idx];
                        out_valid <= 1'b1;
                        out_last  <= issue_last;
                        if (rd_addr_q == LastAddr) begin
                            rd_addr_q <= '0;
                            pass_q    <= pass_q + 8'd1;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                        // Release the bank as soon as its last word is registered.
                        if (issue_last) begin
                            bank_full[rd_bank_q] <= 1'b0;
                            rd_bank_q            <= ~rd_bank_q;
                            state_q              <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ib_pingpong.md
Name: ib_pingpong

Overview:
Parametrised, double-banked (ping-pong) input buffer for the CNN datapath. One bank fills from the upstream stream while the other bank is streamed out to the PE array. Each word of the read bank can be replayed a programmable number of times without refilling. Uses valid/ready handshakes on both sides and presents the full read bank in parallel on cbuffer.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 4, words per bank (>=2)
AW, 8, address/counter width; must satisfy 2^AW > DEPTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
clr  input  1  synchronous clear, same effect as reset, highest priority
in_valid  input  1  upstream word valid
in_ready  output  1  buffer can accept a word this cycle
in_data  input  WIDTH  upstream word
rd_start  input  1  pulse: begin streaming the current read bank
rd_passes  input  8  number of passes over the bank, sampled at rd_start; 0 treated as 1
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  streamed word
out_last  output  1  marks the final word of the final pass
bank_full  output  2  per-bank full flags; bit b = bank b full
rd_busy  output  1  read FSM in STREAM
wr_addr  output  AW  next write index in the write bank
cbuffer  output  DEPTH*WIDTH  all words of the read bank, word 0 in the LSBs (combinational)

Behaviour:
- Reset (rst low, async) or clr high at a clock edge:
  - all bank words = 0; bank_full = 0; wr_bank = 0; rd_bank = 0; wr_addr = 0
  - read FSM = IDLE; out_valid = 0, out_data = 0, out_last = 0
  - rd_busy = 0; pass counter = 0.
- clr overrides every simultaneous write, read or start in the same cycle.
- Write side:
  - in_ready = !bank_full[wr_bank].
  - On in_valid && in_ready: mem[wr_bank][wr_addr] <= in_data; wr_addr++.
  - On the write with wr_addr == DEPTH-1: bank_full[wr_bank] <= 1, wr_bank toggles, wr_addr <= 0.
  - A word offered with in_ready low is not written; upstream holds it.
- Read FSM, states IDLE and STREAM:
  - IDLE -> STREAM on rd_start && bank_full[rd_bank]. Latch passes = max(rd_passes, 1); rd_addr = 0; pass = 0.
  - rd_start in IDLE with bank not full is ignored; no state change, no output.
  - rd_start while in STREAM is ignored.
- STREAM output is registered, skid-free:
  - An output slot is free when !out_valid || out_ready.
  - On a free slot: out_data <= mem[rd_bank][rd_addr], out_valid <= 1.
  - out_last <= (rd_addr == DEPTH-1 && pass == passes-1).
  - Then rd_addr++. At DEPTH-1, rd_addr wraps to 0 and pass++.
  - First out_valid rises exactly 1 cycle after the accepted rd_start.
  - out_data and out_last hold stable while out_valid && !out_ready.
- End of stream:
  - After the last word is issued, the FSM returns to IDLE.
  - bank_full[rd_bank] is cleared and rd_bank toggles in the same cycle.
  - out_valid stays high until that last word is accepted by out_ready, then drops to 0 (out_data returns to 0).
  - A new rd_start is accepted only once out_valid is 0 or the last word is handshaken in that cycle.
- Simultaneous events:
  - A bank release and a writer stalled on that bank: in_ready rises the following cycle.
  - A write filling bank A while the reader releases bank B in the same cycle: both take effect; no conflict.
- rd_busy = (state == STREAM).
- cbuffer always reflects mem[rd_bank], including during fill of the other bank.
- Throughput: with in_valid and out_ready held high and passes = 1, the buffer sustains 1 word/cycle on each side.

Test Plan:
- Fill then single pass, DEPTH=4. Write 0x11, 0x22, 0x33, 0x44. Expect bank_full = 01 and wr_bank = 1. rd_start with rd_passes=1 -> out_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after start. out_last only on 0x44. Then bank_full = 00.
- Replay. Bank holds A, B, C, D; rd_passes=3 -> 12 words A B C D A B C D A B C D. out_last only on the 12th. rd_passes=0 behaves as 1 pass.
- Ping-pong overlap. Fill bank0; start reading it while writing E, F, G, H into bank1 concurrently. Expect no stall: in_ready stays 1. After bank0 is released, cbuffer = {H, G, F, E}.
- Backpressure. Drop out_ready for 3 cycles after the 2nd word -> out_data stays 0x22 with out_valid=1. Stream resumes with 0x33 and no word is lost or duplicated.
- Full stall. Fill both banks (8 writes) -> in_ready=0. A 9th in_valid is not written. in_ready returns to 1 the cycle after bank0 finishes its stream.
- Reset and clear. Assert rst low mid-stream (async) -> out_valid, bank_full, wr_addr and cbuffer all 0 immediately. Repeat with clr=1 together with in_valid and rd_start -> everything cleared and the write ignored.
